// File: rtl/psdsqrt_param.sv
// Parametrised sequential integer square root: floor(sqrt(xin)) and remainder xin - root^2.
// Latency: done is high in the cycle after edge k+NBITSOUT+1, where start is sampled at edge k.
// Backpressure: none. start is ignored while busy, and abort cancels the operation without a done pulse.
//
// Ports:
//   clock  - master clock, rising edge
//   reset  - asynchronous active-low reset
//   start  - one-cycle request, sampled only in IDLE
//   abort  - cancel request; wins over start in IDLE
//   xin    - NBITSIN-bit operand, captured on the accepting edge
//   busy   - high in CALC and FINISH (combinational from the state register)
//   done   - one-cycle pulse when sqrt/rem are updated
//   sqrt   - root result (NBITSIN/2 bits), held until the next done
//   rem    - floor remainder (NBITSIN/2+1 bits), held until the next done
//
// Optional feature macro: PSDSQRT_ROUND_EN. When defined, sqrt is rounded to nearest and
// saturates at all-ones. rem always reports the floor remainder.
module psdsqrt_param #(
    parameter  int NBITSIN  = 32,           // even, >= 4
    localparam int NBITSOUT = NBITSIN / 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [NBITSIN-1:0]  xin,
    output logic                busy,
    output logic                done,
    output logic [NBITSOUT-1:0] sqrt,
    output logic [NBITSOUT:0]   rem
);

    localparam int CNTW = (NBITSOUT > 1) ? $clog2(NBITSOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [NBITSIN-1:0]    x_q, x_d;        // operand, shifted left two bits per iteration
    logic [NBITSOUT-1:0]   root_q, root_d;  // partial root
    logic [NBITSOUT:0]     prem_q, prem_d;  // partial remainder, never negative once stored
    logic [NBITSOUT-1:0]   sqrt_q, sqrt_d;
    logic [NBITSOUT:0]     rem_q, rem_d;
    logic                  done_q, done_d;

    // The trial subtraction is evaluated one bit wider than any operand magnitude can reach,
    // so the top bit acts as the sign. The stored remainder is at most 2*root, which means
    // it always fits in NBITSOUT+1 bits. Shifting it up by two bits can therefore never overflow.
    logic [NBITSOUT+2:0]   shifted_w;
    logic [NBITSOUT+2:0]   sub_w;
    logic [NBITSOUT+2:0]   trial_w;
    logic                  trial_neg_w;
    logic                  unused_bits_w;

    assign shifted_w     = {prem_q, x_q[NBITSIN-1 -: 2]};
    assign sub_w         = {1'b0, root_q, 2'b01};
    assign trial_w       = shifted_w - sub_w;
    assign trial_neg_w   = trial_w[NBITSOUT+2];
    assign unused_bits_w = ^{trial_w[NBITSOUT+1], shifted_w[NBITSOUT+2:NBITSOUT+1]};

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sqrt = sqrt_q;
    assign rem  = rem_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            root_q  <= '0;
            prem_q  <= '0;
            sqrt_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            root_q  <= root_d;
            prem_q  <= prem_d;
            sqrt_q  <= sqrt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        root_d  = root_q;
        prem_d  = prem_q;
        sqrt_d  = sqrt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = CALC;
                    x_d     = xin;
                    cnt_d   = CNTW'(NBITSOUT - 1);
                    root_d  = '0;
                    prem_d  = '0;
                end
            end

            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Restoring step: keep the trial difference only if it is non-negative.
                    root_d = {root_q[NBITSOUT-2:0], ~trial_neg_w};
                    prem_d = trial_neg_w ? shifted_w[NBITSOUT:0] : trial_w[NBITSOUT:0];
                    x_d    = {x_q[NBITSIN-3:0], 2'b00};
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = FINISH;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
                if (!abort) begin
`ifdef PSDSQRT_ROUND_EN
                    // Round up when the remainder exceeds the root, i.e. x >= (r+0.5)^2.
                    // An all-ones root cannot be incremented, so it saturates instead.
                    if ((prem_q > {1'b0, root_q}) && (root_q != '1)) begin
                        sqrt_d = root_q + 1'b1;
                    end else begin
                        sqrt_d = root_q;
                    end
`else
                    sqrt_d = root_q;
`endif
                    rem_d  = prem_q;
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_psdsqrt_param.sv
module tb_psdsqrt_param;

    localparam int NBO32 = 16;
    localparam int NBO8  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] xin   = '0;
    logic        busy, done;
    logic [15:0] sqrt;
    logic [16:0] rem;

    logic        start8 = 1'b0;
    logic        abort8 = 1'b0;
    logic [7:0]  xin8   = '0;
    logic        busy8, done8;
    logic [3:0]  sqrt8;
    logic [4:0]  rem8;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    longint last_s = 0;
    longint last_r = 0;

    typedef struct {
        longint s;
        longint r;
        longint due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    psdsqrt_param #(.NBITSIN(32)) dut32 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .xin(xin),
        .busy(busy), .done(done), .sqrt(sqrt), .rem(rem)
    );

    psdsqrt_param #(.NBITSIN(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .abort(abort8), .xin(xin8),
        .busy(busy8), .done(done8), .sqrt(sqrt8), .rem(rem8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // Reference: largest r with r*r <= x, found from a floating estimate and corrected exactly.
    function automatic void golden(input longint x, input int nbo, output longint s, output longint r);
        longint f;
        f = longint'($sqrt(real'(x)));
        while (f * f > x) f--;
        while ((f + 1) * (f + 1) <= x) f++;
        r = x - f * f;
        s = f;
`ifdef PSDSQRT_ROUND_EN
        if (r > f && f < ((longint'(1) << nbo) - 1)) s = f + 1;
`endif
    endfunction

    // Monitors: pop an expectation whenever done is seen.
    always @(negedge clock) begin
        if (done) begin
            if (q32.size() == 0) begin
                check("done32_without_request", longint'(done), 0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check("sqrt32", longint'(sqrt), e.s);
                check("rem32", longint'(rem), e.r);
                check("latency32", cyc, e.due);
                last_s = e.s;
                last_r = e.r;
            end
        end
    end

    always @(negedge clock) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("done8_without_request", longint'(done8), 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sqrt8", longint'(sqrt8), e.s);
                check("rem8", longint'(rem8), e.r);
                check("latency8", cyc, e.due);
            end
        end
    end

    task automatic issue32(input logic [31:0] x, input bit expect_result);
        int     n = 0;
        longint s, r;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("issue32_wait_idle", longint'(busy), 0);
        start = 1'b1;
        xin   = x;
        if (expect_result) begin
            golden(longint'(x), NBO32, s, r);
            q32.push_back('{s, r, cyc + NBO32 + 2});
        end
        @(negedge clock);
        start = 1'b0;
        xin   = $urandom;
        check("busy32_after_start", longint'(busy), 1);
    endtask

    task automatic issue8(input logic [7:0] x);
        int     n = 0;
        longint s, r;
        @(negedge clock);
        while (busy8 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy8) check("issue8_wait_idle", longint'(busy8), 0);
        start8 = 1'b1;
        xin8   = x;
        golden(longint'(x), NBO8, s, r);
        q8.push_back('{s, r, cyc + NBO8 + 2});
        @(negedge clock);
        start8 = 1'b0;
        xin8   = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", longint'(q32.size() + q8.size()), 0);
    endtask

    initial begin
        logic [31:0] directed [5];
        directed[0] = 32'd123456;
        directed[1] = 32'd0;
        directed[2] = 32'hFFFF_FFFF;
        directed[3] = 32'd15;
        directed[4] = 32'd12;

        // Reset state.
        repeat (3) @(negedge clock);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_sqrt", longint'(sqrt), 0);
        check("reset_rem", longint'(rem), 0);
        reset = 1'b1;

        // A completed result, then a reset in the middle of CALC. The reset must clear the outputs at once.
        issue32(32'd123456, 1'b1);
        issue32(32'd99999, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset_busy", longint'(busy), 0);
        check("midreset_sqrt", longint'(sqrt), 0);
        check("midreset_rem", longint'(rem), 0);
        last_s = 0;
        last_r = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (25) @(negedge clock);

        // Directed operands. Each issue lands in the done cycle of the previous one.
        foreach (directed[i]) issue32(directed[i], 1'b1);

        // A start while busy is ignored.
        issue32(32'd1000000, 1'b1);
        repeat (3) @(negedge clock);
        start = 1'b1;
        xin   = 32'd77;
        @(negedge clock);
        start = 1'b0;

        // Abort mid-CALC: no done, and the previous outputs are held.
        issue32(32'd4000000, 1'b0);
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", longint'(busy), 0);
        repeat (25) @(negedge clock);
        check("abort_hold_sqrt", longint'(sqrt), last_s);
        check("abort_hold_rem", longint'(rem), last_r);

        // start together with abort in IDLE does not launch an operation.
        start = 1'b1;
        abort = 1'b1;
        xin   = 32'd5;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", longint'(busy), 0);

        // Random operands, with the boundary values mixed in.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] x;
            case ($urandom_range(0, 9))
                0:       x = 32'($urandom_range(0, 300));
                1: begin
                    logic [15:0] k;
                    k = 16'($urandom);
                    x = 32'(k) * 32'(k) + 32'($urandom_range(0, 1)) * 32'(k);
                end
                2:       x = 32'hFFFF_FFFF - 32'($urandom_range(0, 70000));
                default: x = $urandom;
            endcase
            issue32(x, 1'b1);
        end

        // Exhaustive 8-bit sweep.
        for (int x = 0; x < 256; x++) issue8(8'(x));

        drain();
        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
